exu_csr_core: RTL and testbench



---
 rtl/exu_csr_core_pkg.sv | 54 +++++
 rtl/exu_csr_core_if.sv | 29 ++
 rtl/exu_csr_core_rst_delay.sv | 30 +++
 rtl/exu_csr_core.sv | 187 ++++++++++++++++++
 tb/tb_exu_csr_core.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/exu_csr_core_pkg.sv
// -----------------------------------------------------------------------------
// exu_csr_core_pkg
// Shared widths, opcode and operand-select encodings, machine-mode CSR
// addresses and reset values for the fused execute unit / CSR file.
// -----------------------------------------------------------------------------
package exu_csr_core_pkg;

   localparam int XLEN   = 32;
   localparam int OPT_W  = 4;
   localparam int SEL_W  = 3;
   localparam int CSR_AW = 12;

   // Execute-unit operations. Encodings 13..15 are reserved and produce 0.
   typedef enum logic [OPT_W-1:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_SLL   = 4'd5,
      OP_SRL   = 4'd6,
      OP_SRA   = 4'd7,
      OP_SLT   = 4'd8,
      OP_SLTU  = 4'd9,
      OP_CSRRW = 4'd10,
      OP_CSRRS = 4'd11,
      OP_CSRRC = 4'd12
   } exu_op_e;

   // Operand selects. Encoding 7 drives both operands to zero.
   typedef enum logic [SEL_W-1:0] {
      SEL_RS1_RS2  = 3'd0,
      SEL_RS1_IMM  = 3'd1,
      SEL_PC_IMM   = 3'd2,
      SEL_PC_4     = 3'd3,
      SEL_ZERO_IMM = 3'd4,
      SEL_CSR_RS1  = 3'd5,
      SEL_CSR_IMM  = 3'd6,
      SEL_NONE     = 3'd7
   } exu_sel_e;

   localparam logic [CSR_AW-1:0] CSR_MSTATUS  = 12'h300;
   localparam logic [CSR_AW-1:0] CSR_MTVEC    = 12'h305;
   localparam logic [CSR_AW-1:0] CSR_MSCRATCH = 12'h340;
   localparam logic [CSR_AW-1:0] CSR_MEPC     = 12'h341;
   localparam logic [CSR_AW-1:0] CSR_MCAUSE   = 12'h342;

   localparam logic [XLEN-1:0] MSTATUS_RST = 32'h0000_1800;

   function automatic logic is_csr_op(input logic [OPT_W-1:0] op);
      return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
   endfunction

endpackage

// File: rtl/exu_csr_core_if.sv
// -----------------------------------------------------------------------------
// exu_csr_core_if
// CSR access bus between the decoder (master) and the CSR file (slave).
//   wr_en_csr    master->slave  write strobe
//   addr_wr_csr  master->slave  write address
//   data_wr_csr  master->slave  write data
//   addr_rd_csr  master->slave  read address
//   data_rd_csr  slave->master  combinational read data
// -----------------------------------------------------------------------------
interface exu_csr_core_if;
   import exu_csr_core_pkg::*;

   logic              wr_en_csr;
   logic [CSR_AW-1:0] addr_wr_csr;
   logic [CSR_AW-1:0] addr_rd_csr;
   logic [XLEN-1:0]   data_wr_csr;
   logic [XLEN-1:0]   data_rd_csr;

   modport master (
      output wr_en_csr, addr_wr_csr, addr_rd_csr, data_wr_csr,
      input  data_rd_csr
   );

   modport slave (
      input  wr_en_csr, addr_wr_csr, addr_rd_csr, data_wr_csr,
      output data_rd_csr
   );

endinterface

// File: rtl/exu_csr_core_rst_delay.sv
// -----------------------------------------------------------------------------
// rst_delay
// Registers the incoming reset for one cycle; the delayed copy resets the
// rest of the core.
//   clk    in   rising-edge clock
//   rst_i  in   reset input (active-high)
//   rst_o  out  rst_i delayed by one rising edge
// -----------------------------------------------------------------------------
module rst_delay (
   input  logic clk,
   input  logic rst_i,
   output logic rst_o
);

   logic rst_d;
   logic rst_q;

   always_comb begin
      rst_d = rst_i;
   end

   // NOTE: this flop is the reset source, so it carries no reset of its own;
   // its value is unknown until the first clock edge after power-up.
   always_ff @(posedge clk) begin
      rst_q <= rst_d;
   end

   assign rst_o = rst_q;

endmodule

// File: rtl/exu_csr_core.sv
// -----------------------------------------------------------------------------
// exu_csr_core
// Combinational RV32 execute unit fused with the machine-mode CSR file
// (mstatus, mtvec, mepc, mcause) and ecall trap capture.
//
// Build option: define EXU_CSR_MSCRATCH_EN to add mscratch at 0x340;
// otherwise 0x340 is unmapped (reads 0, writes ignored).
//
// Ports:
//   clk           in   rising-edge clock
//   rstn          in   synchronous reset, active-high
//   rstn_sync     out  rstn delayed one edge; resets the CSRs and the core
//   pc            in   current instruction address
//   data_Rs1/Rs2  in   GPR operands
//   imm           in   immediate
//   exu_opt_code  in   operation (exu_op_e)
//   exu_sel_code  in   operand select (exu_sel_e)
//   ecall_en      in   capture a trap this cycle
//   ecall_NO      in   trap cause code
//   csr_bus       slave CSR read/write bus
//   exu_res       out  ALU result, or old CSR value for CSR ops
//   csr_res       out  new CSR value for CSR ops
//   csr_res_en    out  high for CSRRW/CSRRS/CSRRC
//   zero          out  exu_res == 0
//   mtvec, mepc   out  direct CSR taps
// -----------------------------------------------------------------------------
module exu_csr_core
   import exu_csr_core_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   output logic             rstn_sync,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  data_Rs1,
   input  logic [XLEN-1:0]  data_Rs2,
   input  logic [XLEN-1:0]  imm,
   input  logic [OPT_W-1:0] exu_opt_code,
   input  logic [SEL_W-1:0] exu_sel_code,
   input  logic             ecall_en,
   input  logic [7:0]       ecall_NO,
   exu_csr_core_if.slave    csr_bus,
   output logic [XLEN-1:0]  exu_res,
   output logic [XLEN-1:0]  csr_res,
   output logic             csr_res_en,
   output logic             zero,
   output logic [XLEN-1:0]  mtvec,
   output logic [XLEN-1:0]  mepc
);

   // ---------------------------------------------------------------- reset
   rst_delay u_rst_delay (
      .clk   (clk),
      .rst_i (rstn),
      .rst_o (rstn_sync)
   );

   // ------------------------------------------------------------- CSR file
   logic [XLEN-1:0] mstatus_d, mstatus_q;
   logic [XLEN-1:0] mtvec_d,   mtvec_q;
   logic [XLEN-1:0] mepc_d,    mepc_q;
   logic [XLEN-1:0] mcause_d,  mcause_q;
`ifdef EXU_CSR_MSCRATCH_EN
   logic [XLEN-1:0] mscratch_d, mscratch_q;
`endif

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      mstatus_d = mstatus_q;
      mtvec_d   = mtvec_q;
      mepc_d    = mepc_q;
      mcause_d  = mcause_q;
`ifdef EXU_CSR_MSCRATCH_EN
      mscratch_d = mscratch_q;
`endif
      if (csr_bus.wr_en_csr) begin
         case (csr_bus.addr_wr_csr)
            CSR_MSTATUS:  mstatus_d  = csr_bus.data_wr_csr;
            CSR_MTVEC:    mtvec_d    = csr_bus.data_wr_csr;
            CSR_MEPC:     mepc_d     = csr_bus.data_wr_csr;
            CSR_MCAUSE:   mcause_d   = csr_bus.data_wr_csr;
`ifdef EXU_CSR_MSCRATCH_EN
            CSR_MSCRATCH: mscratch_d = csr_bus.data_wr_csr;
`endif
            default: ;
         endcase
      end
      // Trap capture is applied last so it overrides a same-cycle software
      // write to mepc/mcause; writes to other CSRs are untouched.
      if (ecall_en) begin
         mepc_d   = pc;
         mcause_d = {24'b0, ecall_NO};
      end
   end

   // Reset comes from the delayed copy and beats both writes and traps.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rstn_sync) begin
         mstatus_q <= MSTATUS_RST;
         mtvec_q   <= '0;
         mepc_q    <= '0;
         mcause_q  <= '0;
`ifdef EXU_CSR_MSCRATCH_EN
         mscratch_q <= '0;
`endif
      end else begin
         mstatus_q <= mstatus_d;
         mtvec_q   <= mtvec_d;
         mepc_q    <= mepc_d;
         mcause_q  <= mcause_d;
`ifdef EXU_CSR_MSCRATCH_EN
         mscratch_q <= mscratch_d;
`endif
      end
   end

   // Read port reflects current state only; a write in flight is not seen
   // until the following cycle.
   always_comb begin
      csr_bus.data_rd_csr = '0;
      case (csr_bus.addr_rd_csr)
         CSR_MSTATUS:  csr_bus.data_rd_csr = mstatus_q;
         CSR_MTVEC:    csr_bus.data_rd_csr = mtvec_q;
         CSR_MEPC:     csr_bus.data_rd_csr = mepc_q;
         CSR_MCAUSE:   csr_bus.data_rd_csr = mcause_q;
`ifdef EXU_CSR_MSCRATCH_EN
         CSR_MSCRATCH: csr_bus.data_rd_csr = mscratch_q;
`endif
         default: ;
      endcase
   end

   assign mtvec = mtvec_q;
   assign mepc  = mepc_q;

   // ------------------------------------------------------ operand select
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [4:0]      shamt;

   always_comb begin
      op_a = '0;
      op_b = '0;
      case (exu_sel_code)
         SEL_RS1_RS2:  begin op_a = data_Rs1;            op_b = data_Rs2; end
         SEL_RS1_IMM:  begin op_a = data_Rs1;            op_b = imm;      end
         SEL_PC_IMM:   begin op_a = pc;                  op_b = imm;      end
         SEL_PC_4:     begin op_a = pc;                  op_b = 32'd4;    end
         SEL_ZERO_IMM: begin op_a = '0;                  op_b = imm;      end
         SEL_CSR_RS1:  begin op_a = csr_bus.data_rd_csr; op_b = data_Rs1; end
         SEL_CSR_IMM:  begin op_a = csr_bus.data_rd_csr; op_b = imm;      end
         default: ;
      endcase
   end

   assign shamt = op_b[4:0];

   // ------------------------------------------------------------------ ALU
   always_comb begin
      exu_res = '0;
      csr_res = '0;
      case (exu_opt_code)
         OP_ADD:  exu_res = op_a + op_b;
         OP_SUB:  exu_res = op_a - op_b;
         OP_AND:  exu_res = op_a & op_b;
         OP_OR:   exu_res = op_a | op_b;
         OP_XOR:  exu_res = op_a ^ op_b;
         OP_SLL:  exu_res = op_a << shamt;
         OP_SRL:  exu_res = op_a >> shamt;
         OP_SRA:  exu_res = XLEN'($signed(op_a) >>> shamt);
         OP_SLT:  exu_res = {31'b0, $signed(op_a) < $signed(op_b)};
         OP_SLTU: exu_res = {31'b0, op_a < op_b};
         // CSR ops return the old CSR value and present the updated value
         // on csr_res for the write-back stage to commit.
         OP_CSRRW: begin exu_res = op_a; csr_res = op_b;          end
         OP_CSRRS: begin exu_res = op_a; csr_res = op_a | op_b;   end
         OP_CSRRC: begin exu_res = op_a; csr_res = op_a & ~op_b;  end
         default: ;
      endcase
   end

   assign csr_res_en = is_csr_op(exu_opt_code);
   assign zero       = (exu_res == '0);

endmodule

// File: tb/tb_exu_csr_core.sv
module tb_exu_csr_core;
   import exu_csr_core_pkg::*;

   logic             clk;
   logic             rstn;
   logic             rstn_sync;
   logic [31:0]      pc, data_Rs1, data_Rs2, imm;
   logic [3:0]       exu_opt_code;
   logic [2:0]       exu_sel_code;
   logic             ecall_en;
   logic [7:0]       ecall_NO;
   logic [31:0]      exu_res, csr_res, mtvec, mepc;
   logic             csr_res_en, zero;

   exu_csr_core_if csr_bus ();

   exu_csr_core dut (
      .clk          (clk),
      .rstn         (rstn),
      .rstn_sync    (rstn_sync),
      .pc           (pc),
      .data_Rs1     (data_Rs1),
      .data_Rs2     (data_Rs2),
      .imm          (imm),
      .exu_opt_code (exu_opt_code),
      .exu_sel_code (exu_sel_code),
      .ecall_en     (ecall_en),
      .ecall_NO     (ecall_NO),
      .csr_bus      (csr_bus.slave),
      .exu_res      (exu_res),
      .csr_res      (csr_res),
      .csr_res_en   (csr_res_en),
      .zero         (zero),
      .mtvec        (mtvec),
      .mepc         (mepc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef EXU_CSR_MSCRATCH_EN
   localparam logic [31:0] SCRATCH_EXP = 32'h0000_BEEF;
`else
   localparam logic [31:0] SCRATCH_EXP = 32'h0;
`endif

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   // Vector table and scoreboard
   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [2:0]  sel;
      logic [31:0] rs1, rs2, imm, pc;
      logic [11:0] csr_addr;
      logic [31:0] exp_res;
      logic        exp_zero;
      logic        exp_en;
      logic        chk_csr;
      logic [31:0] exp_csr;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic        zero;
      logic        en;
      logic        chk_csr;
      logic [31:0] csr;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];

   task automatic add_vec(input string name, input logic [3:0] op, input logic [2:0] sel,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] im,
                          input logic [31:0] p, input logic [11:0] ca,
                          input logic [31:0] er, input logic ez, input logic een,
                          input logic cc, input logic [31:0] ecs);
      vec_t v;
      v.name = name; v.op = op; v.sel = sel; v.rs1 = rs1; v.rs2 = rs2; v.imm = im;
      v.pc = p; v.csr_addr = ca; v.exp_res = er; v.exp_zero = ez; v.exp_en = een;
      v.chk_csr = cc; v.exp_csr = ecs;
      vecs.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      pc = '0; data_Rs1 = '0; data_Rs2 = '0; imm = '0;
      exu_opt_code = OP_ADD; exu_sel_code = SEL_NONE;
      ecall_en = 1'b0; ecall_NO = '0;
      csr_bus.wr_en_csr = 1'b0; csr_bus.addr_wr_csr = '0;
      csr_bus.addr_rd_csr = '0; csr_bus.data_wr_csr = '0;
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
      csr_bus.wr_en_csr = 1'b1; csr_bus.addr_wr_csr = a; csr_bus.data_wr_csr = d;
      tick();
      csr_bus.wr_en_csr = 1'b0;
   endtask

   task automatic csr_read_check(input string name, input logic [11:0] a, input logic [31:0] exp);
      csr_bus.addr_rd_csr = a;
      #1;
      check(name, csr_bus.data_rd_csr, exp);
   endtask

   initial begin
      exp_t e;
      idle_inputs();
      rstn = 1'b1;

      // ------------------------------------------------ reset sequence
      @(posedge clk); @(negedge clk);
      check("rstn_sync_rise", {31'b0, rstn_sync}, 32'h1);
      tick();
      check("rstn_sync_held", {31'b0, rstn_sync}, 32'h1);
      rstn = 1'b0;
      tick();
      check("rstn_sync_fall", {31'b0, rstn_sync}, 32'h0);
      csr_read_check("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
      csr_read_check("rst_mtvec",   CSR_MTVEC,   32'h0);
      csr_read_check("rst_mepc",    CSR_MEPC,    32'h0);
      csr_read_check("rst_mcause",  CSR_MCAUSE,  32'h0);
      check("rst_mtvec_tap", mtvec, 32'h0);
      check("rst_mepc_tap",  mepc,  32'h0);

      // ------------------------------------------------ ALU / CSR table
      add_vec("sub_eq",   OP_SUB,  SEL_RS1_RS2, 5, 5, 0, 0, 0, 32'h0, 1, 0, 0, 0);
      add_vec("sra_neg",  OP_SRA,  SEL_RS1_IMM, 32'h8000_0000, 0, 4, 0, 0, 32'hF800_0000, 0, 0, 0, 0);
      add_vec("sltu",     OP_SLTU, SEL_RS1_RS2, 1, 32'hFFFF_FFFF, 0, 0, 0, 32'h1, 0, 0, 0, 0);
      add_vec("slt",      OP_SLT,  SEL_RS1_RS2, 1, 32'hFFFF_FFFF, 0, 0, 0, 32'h0, 1, 0, 0, 0);
      add_vec("slt_neg",  OP_SLT,  SEL_RS1_RS2, 32'hFFFF_FFFE, 1, 0, 0, 0, 32'h1, 0, 0, 0, 0);
      add_vec("pc_4",     OP_ADD,  SEL_PC_4, 0, 0, 0, 32'h8000_0010, 0, 32'h8000_0014, 0, 0, 0, 0);
      add_vec("pc_imm",   OP_ADD,  SEL_PC_IMM, 0, 0, 32'hFFFF_FFF0, 32'h100, 0, 32'h0F0, 0, 0, 0, 0);
      add_vec("add_wrap", OP_ADD,  SEL_RS1_RS2, 32'hFFFF_FFFF, 2, 0, 0, 0, 32'h1, 0, 0, 0, 0);
      add_vec("sub_wrap", OP_SUB,  SEL_RS1_RS2, 0, 1, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
      add_vec("sll_mask", OP_SLL,  SEL_RS1_IMM, 1, 0, 32'h23, 0, 0, 32'h8, 0, 0, 0, 0);
      add_vec("srl_31",   OP_SRL,  SEL_RS1_RS2, 32'h8000_0000, 31, 0, 0, 0, 32'h1, 0, 0, 0, 0);
      add_vec("xor",      OP_XOR,  SEL_RS1_RS2, 32'hF0F0, 32'hFF00, 0, 0, 0, 32'h0FF0, 0, 0, 0, 0);
      add_vec("and_imm",  OP_AND,  SEL_RS1_IMM, 32'hFF, 0, 32'h0F, 0, 0, 32'h0F, 0, 0, 0, 0);
      add_vec("or_zimm",  OP_OR,   SEL_ZERO_IMM, 32'hFFFF, 0, 32'h123, 0, 0, 32'h123, 0, 0, 0, 0);
      add_vec("sel7",     OP_ADD,  SEL_NONE, 7, 9, 3, 32'h40, 0, 32'h0, 1, 0, 0, 0);
      add_vec("op13",     4'd13,   SEL_RS1_RS2, 5, 7, 0, 0, 0, 32'h0, 1, 0, 0, 0);
      add_vec("op15",     4'd15,   SEL_RS1_RS2, 5, 7, 0, 0, 0, 32'h0, 1, 0, 0, 0);
      add_vec("csrrs_ms", OP_CSRRS, SEL_CSR_RS1, 32'h3, 0, 0, 0, CSR_MSTATUS, 32'h1800, 0, 1, 1, 32'h1803);
      add_vec("csrrc_ms", OP_CSRRC, SEL_CSR_IMM, 0, 0, 32'h800, 0, CSR_MSTATUS, 32'h1800, 0, 1, 1, 32'h1000);
      add_vec("csrrw_ms", OP_CSRRW, SEL_CSR_RS1, 32'hABC, 0, 0, 0, CSR_MSTATUS, 32'h1800, 0, 1, 1, 32'h0ABC);
      add_vec("csrrw_0",  OP_CSRRW, SEL_CSR_IMM, 0, 0, 32'h7, 0, CSR_MEPC, 32'h0, 1, 1, 1, 32'h7);

      foreach (vecs[i]) begin
         @(negedge clk);
         exu_opt_code = vecs[i].op; exu_sel_code = vecs[i].sel;
         data_Rs1 = vecs[i].rs1; data_Rs2 = vecs[i].rs2; imm = vecs[i].imm;
         pc = vecs[i].pc; csr_bus.addr_rd_csr = vecs[i].csr_addr;
         e.name = vecs[i].name; e.res = vecs[i].exp_res; e.zero = vecs[i].exp_zero;
         e.en = vecs[i].exp_en; e.chk_csr = vecs[i].chk_csr; e.csr = vecs[i].exp_csr;
         sb_q.push_back(e);
         #1;
         e = sb_q.pop_front();
         check({e.name, "_res"},  exu_res, e.res);
         check({e.name, "_zero"}, {31'b0, zero}, {31'b0, e.zero});
         check({e.name, "_en"},   {31'b0, csr_res_en}, {31'b0, e.en});
         if (e.chk_csr) check({e.name, "_csr"}, csr_res, e.csr);
      end
      check("sb_empty", sb_q.size(), 0);
      @(negedge clk);
      idle_inputs();

      // ------------------------------------------------ CSRRS on mtvec
      csr_write(CSR_MTVEC, 32'h100);
      check("mtvec_100", mtvec, 32'h100);
      exu_opt_code = OP_CSRRS; exu_sel_code = SEL_CSR_RS1;
      data_Rs1 = 32'h3; csr_bus.addr_rd_csr = CSR_MTVEC;
      #1;
      check("mtvec_rs_old", exu_res, 32'h100);
      check("mtvec_rs_new", csr_res, 32'h103);
      check("mtvec_rs_en",  {31'b0, csr_res_en}, 32'h1);
      csr_bus.wr_en_csr = 1'b1; csr_bus.addr_wr_csr = CSR_MTVEC; csr_bus.data_wr_csr = 32'h103;
      #1;
      check("no_bypass", csr_bus.data_rd_csr, 32'h100);
      tick();
      csr_bus.wr_en_csr = 1'b0;
      check("mtvec_103", mtvec, 32'h103);
      csr_read_check("mtvec_rd_103", CSR_MTVEC, 32'h103);
      idle_inputs();

      // ------------------------------------------------ other CSRs R/W
      csr_write(CSR_MSTATUS, 32'h88);
      csr_read_check("mstatus_wr", CSR_MSTATUS, 32'h88);
      csr_write(CSR_MCAUSE, 32'h1234);
      csr_read_check("mcause_wr", CSR_MCAUSE, 32'h1234);

      // ------------------------------------------------ ecall vs write
      pc = 32'h8000_0040; ecall_NO = 8'd11; ecall_en = 1'b1;
      csr_write(CSR_MEPC, 32'h55);
      ecall_en = 1'b0;
      check("ecall_mepc", mepc, 32'h8000_0040);
      csr_read_check("ecall_mcause", CSR_MCAUSE, 32'd11);
      pc = 32'h200; ecall_NO = 8'd8; ecall_en = 1'b1;
      csr_write(CSR_MTVEC, 32'h44);
      ecall_en = 1'b0;
      check("ecall2_mtvec", mtvec, 32'h44);
      check("ecall2_mepc",  mepc,  32'h200);
      csr_read_check("ecall2_mcause", CSR_MCAUSE, 32'd8);

      // ------------------------------------------------ unmapped / mscratch
      csr_write(12'h7C0, 32'hDEAD);
      csr_read_check("unmapped_7c0", 12'h7C0, 32'h0);
      csr_write(CSR_MSCRATCH, 32'hBEEF);
      csr_read_check("mscratch", CSR_MSCRATCH, SCRATCH_EXP);
      csr_read_check("mstatus_kept", CSR_MSTATUS, 32'h88);

      // ------------------------------------------------ reset during ecall
      rstn = 1'b1; ecall_en = 1'b1; pc = 32'h8000_0080; ecall_NO = 8'd5;
      tick();   // rstn_sync still low at this edge: capture happens
      check("rst_ecall_pre", mepc, 32'h8000_0080);
      check("rst_ecall_sync", {31'b0, rstn_sync}, 32'h1);
      tick();   // rstn_sync high: reset wins over the trap
      check("rst_ecall_mepc", mepc, 32'h0);
      csr_read_check("rst_ecall_mcause", CSR_MCAUSE, 32'h0);
      csr_read_check("rst_ecall_mstatus", CSR_MSTATUS, 32'h1800);
      rstn = 1'b0; ecall_en = 1'b0;
      tick();
      tick();
      check("rst_ecall_release", {31'b0, rstn_sync}, 32'h0);
      check("rst_ecall_mepc2", mepc, 32'h0);
      check("rst_ecall_mtvec", mtvec, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
